// File: rtl/axil_ram_slave.sv
// AXI4-Lite slave fronting a word-addressed on-chip RAM.
// Writes are buffered in independent AW/W holding registers and commit one
// edge after both are present. Reads come from a synchronous-read array.
// Addresses outside the window answer DECERR.
module axil_ram_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] s_awaddr,
   input  logic [2:0]  s_awprot,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   input  logic        s_wvalid,
   output logic        s_wready,
   output logic [1:0]  s_bresp,
   output logic        s_bvalid,
   input  logic        s_bready,
   input  logic [31:0] s_araddr,
   input  logic [2:0]  s_arprot,
   input  logic        s_arvalid,
   output logic        s_arready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rvalid,
   input  logic        s_rready
);

   localparam int          IDX_W       = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN_BYTES  = 32'(DEPTH_WORDS) << 2;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_DECERR = 2'b11;

   logic [31:0] mem [DEPTH_WORDS];

   logic             aw_full_q, aw_full_d;
   logic [IDX_W-1:0] aw_idx_q,  aw_idx_d;
   logic             aw_ok_q,   aw_ok_d;
   logic             w_full_q,  w_full_d;
   logic [31:0]      wdata_q,   wdata_d;
   logic [3:0]       wstrb_q,   wstrb_d;
   logic             bvalid_q,  bvalid_d;
   logic [1:0]       bresp_q,   bresp_d;
   logic             rvalid_q,  rvalid_d;
   logic [1:0]       rresp_q,   rresp_d;
   logic [31:0]      rdata_q,   rdata_d;

   logic [31:0] aw_off, ar_off;
   logic        aw_in_range, ar_in_range;
   logic        aw_hs, w_hs, ar_hs, commit;

   // Wrapping subtraction folds both window bounds into one unsigned compare.
   assign aw_off      = s_awaddr - BASE_ADDR;
   assign ar_off      = s_araddr - BASE_ADDR;
   assign aw_in_range = (aw_off < SPAN_BYTES);
   assign ar_in_range = (ar_off < SPAN_BYTES);

   // Readies depend only on local state and reset, never on the master's valids.
   assign s_awready = !aw_full_q && !rst;
   assign s_wready  = !w_full_q && !rst;
   assign s_arready = !rvalid_q && !rst;

   assign aw_hs  = s_awvalid && s_awready;
   assign w_hs   = s_wvalid && s_wready;
   assign ar_hs  = s_arvalid && s_arready;
   // Reset blocks the commit so a held AW/W pair never reaches the array.
   assign commit = aw_full_q && w_full_q && (!bvalid_q || s_bready) && !rst;

   assign s_bvalid = bvalid_q;
   assign s_bresp  = bresp_q;
   assign s_rvalid = rvalid_q;
   assign s_rresp  = rresp_q;
   assign s_rdata  = rdata_q;

   logic unused_prot;
   assign unused_prot = ^{s_awprot, s_arprot};

   // Next-state for holding registers and both response channels.
   always_comb begin
      aw_full_d = aw_full_q;
      aw_idx_d  = aw_idx_q;
      aw_ok_d   = aw_ok_q;
      w_full_d  = w_full_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;

      if (commit) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = aw_ok_q ? RESP_OKAY : RESP_DECERR;
      end else if (s_bready) begin
         bvalid_d  = 1'b0;
      end

      if (aw_hs) begin
         aw_full_d = 1'b1;
         aw_idx_d  = aw_off[IDX_W+1:2];
         aw_ok_d   = aw_in_range;
      end

      if (w_hs) begin
         w_full_d = 1'b1;
         wdata_d  = s_wdata;
         wstrb_d  = s_wstrb;
      end

      // Array read sees pre-write contents when it collides with a commit.
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = ar_in_range ? RESP_OKAY : RESP_DECERR;
         rdata_d  = ar_in_range ? mem[ar_off[IDX_W+1:2]] : 32'h0;
      end else if (s_rready) begin
         rvalid_d = 1'b0;
      end
   end

   // Control and response registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         aw_full_q <= 1'b0;
         aw_idx_q  <= '0;
         aw_ok_q   <= 1'b0;
         w_full_q  <= 1'b0;
         wdata_q   <= 32'h0;
         wstrb_q   <= 4'h0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= 32'h0;
      end else begin
         aw_full_q <= aw_full_d;
         aw_idx_q  <= aw_idx_d;
         aw_ok_q   <= aw_ok_d;
         w_full_q  <= w_full_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
      end
   end

   // Byte-enabled write port; array contents survive reset.
   always_ff @(posedge clk) begin
      if (commit && aw_ok_q) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) begin
               mem[aw_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_axil_ram_slave.sv
// Bench for axil_ram_slave: a table of write/read transactions with
// scoreboard queues, then hand-timed sequences for the multi-cycle cases.
module tb_axil_ram_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_awaddr;
   logic [2:0]  s_awprot;
   logic        s_awvalid;
   logic        s_awready;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_wvalid;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready;
   logic [31:0] s_araddr;
   logic [2:0]  s_arprot;
   logic        s_arvalid;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready;

   always #5 clk = ~clk;

   axil_ram_slave dut (
      .clk(clk), .rst(rst),
      .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
   );

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  exp_resp;
      logic [31:0] exp_data;
   } vec_t;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
   } rexp_t;

   logic [1:0] b_q[$];
   rexp_t      r_q[$];
   int         n_vec = 0;
   int         n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
      end
   endtask

   task automatic timeout(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: no response within cycle budget, expected one", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_b(input string name);
      logic [1:0] e;
      e = b_q.pop_front();
      check(name, 32'(s_bresp), 32'(e));
   endtask

   task automatic pop_r(input string name);
      rexp_t e;
      e = r_q.pop_front();
      check({name, "_rresp"}, 32'(s_rresp), 32'(e.resp));
      check({name, "_rdata"}, s_rdata, e.data);
   endtask

   // Issues AW and W together, then waits for and consumes the B beat.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
      bit aw_go, w_go, aw_done, w_done;
      int tries, lat;
      aw_done = 0; w_done = 0; tries = 0;
      s_awaddr = addr; s_wdata = data; s_wstrb = strb;
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
      while (!(aw_done && w_done) && tries < 20) begin
         aw_go = s_awvalid && s_awready;
         w_go  = s_wvalid && s_wready;
         step();
         if (aw_go) begin aw_done = 1; s_awvalid = 1'b0; end
         if (w_go)  begin w_done = 1;  s_wvalid = 1'b0;  end
         tries++;
      end
      if (!(aw_done && w_done)) begin
         s_awvalid = 1'b0; s_wvalid = 1'b0;
         timeout("wr_accept");
         return;
      end
      b_q.push_back(exp_resp);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!s_bvalid && lat < 20);
      if (!s_bvalid) begin
         b_q.delete(0);
         timeout("wr_bvalid");
         step();
         return;
      end
      if (tries == 1) check("wr_latency", 32'(lat), 32'd2);
      pop_b("wr_bresp");
      step();
   endtask

   // Issues AR, then waits for and consumes the R beat.
   task automatic do_read(input logic [31:0] addr, input logic [1:0] exp_resp,
                          input logic [31:0] exp_data);
      bit ar_go, ar_done;
      int tries, lat;
      rexp_t e;
      ar_done = 0; tries = 0;
      s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
      while (!ar_done && tries < 20) begin
         ar_go = s_arvalid && s_arready;
         step();
         if (ar_go) begin ar_done = 1; s_arvalid = 1'b0; end
         tries++;
      end
      if (!ar_done) begin
         s_arvalid = 1'b0;
         timeout("rd_accept");
         return;
      end
      e.resp = exp_resp;
      e.data = exp_data;
      r_q.push_back(e);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!s_rvalid && lat < 20);
      if (!s_rvalid) begin
         r_q.delete(0);
         timeout("rd_rvalid");
         step();
         return;
      end
      if (tries == 1) check("rd_latency", 32'(lat), 32'd1);
      pop_r("rd");
      step();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[$];
      tbl.push_back('{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0});
      tbl.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF});
      tbl.push_back('{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00, 32'h0});
      tbl.push_back('{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0});
      tbl.push_back('{1'b0, 32'h8000_0020, 32'h0,         4'h0, 2'b00, 32'h11BB_33DD});
      tbl.push_back('{1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0});
      tbl.push_back('{1'b0, 32'h8000_0020, 32'h0,         4'h0, 2'b00, 32'h11BB_33DD});
      tbl.push_back('{1'b1, 32'h8000_0000, 32'h0BAD_C0DE, 4'hF, 2'b00, 32'h0});
      tbl.push_back('{1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0});
      tbl.push_back('{1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 2'b11, 32'h0});
      tbl.push_back('{1'b1, 32'h7FFF_FFFC, 32'h5555_5555, 4'hF, 2'b11, 32'h0});
      tbl.push_back('{1'b0, 32'h8000_0000, 32'h0,         4'h0, 2'b00, 32'h0BAD_C0DE});
      tbl.push_back('{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D});
      tbl.push_back('{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 2'b11, 32'h0});
      tbl.push_back('{1'b0, 32'h8000_1000, 32'h0,         4'h0, 2'b11, 32'h0});
      tbl.push_back('{1'b0, 32'h8000_0013, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF});
      tbl.push_back('{1'b1, 32'h8000_0023, 32'h0102_0304, 4'hF, 2'b00, 32'h0});
      tbl.push_back('{1'b0, 32'h8000_0020, 32'h0,         4'h0, 2'b00, 32'h0102_0304});
      tbl.push_back('{1'b1, 32'h8000_0030, 32'h3030_3030, 4'hF, 2'b00, 32'h0});
      tbl.push_back('{1'b1, 32'h8000_0050, 32'h1111_1111, 4'hF, 2'b00, 32'h0});

      rst = 1'b1;
      s_awaddr = '0; s_awprot = 3'b0; s_awvalid = 1'b0;
      s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
      s_araddr = '0; s_arprot = 3'b0; s_arvalid = 1'b0; s_rready = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_awready", 32'(s_awready), 32'd0);
      check("rst_wready",  32'(s_wready),  32'd0);
      check("rst_arready", 32'(s_arready), 32'd0);
      check("rst_bvalid",  32'(s_bvalid),  32'd0);
      check("rst_rvalid",  32'(s_rvalid),  32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_awready", 32'(s_awready), 32'd1);
      check("post_rst_wready",  32'(s_wready),  32'd1);
      check("post_rst_arready", 32'(s_arready), 32'd1);
      check("post_rst_bresp",   32'(s_bresp),   32'd0);
      check("post_rst_rresp",   32'(s_rresp),   32'd0);
      check("post_rst_rdata",   s_rdata,        32'd0);
      step();

      // Table-driven transactions
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].is_wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].exp_resp);
         else              do_read(tbl[i].addr, tbl[i].exp_resp, tbl[i].exp_data);
      end

      // W first, AW three cycles later
      s_bready = 1'b1;
      s_wdata = 32'h5A5A_0001; s_wstrb = 4'hF; s_wvalid = 1'b1;
      step();
      s_wvalid = 1'b0;
      check("wfirst_wready",  32'(s_wready),  32'd0);
      check("wfirst_awready", 32'(s_awready), 32'd1);
      repeat (2) begin
         step();
         check("wfirst_wait_wready", 32'(s_wready), 32'd0);
         check("wfirst_wait_bvalid", 32'(s_bvalid), 32'd0);
      end
      s_awaddr = 32'h8000_0070; s_awvalid = 1'b1;
      step();
      s_awvalid = 1'b0;
      check("wfirst_bvalid_early", 32'(s_bvalid), 32'd0);
      b_q.push_back(2'b00);
      step();
      check("wfirst_bvalid", 32'(s_bvalid), 32'd1);
      pop_b("wfirst_bresp");
      step();
      check("wfirst_bvalid_clear", 32'(s_bvalid), 32'd0);
      do_read(32'h8000_0070, 2'b00, 32'h5A5A_0001);

      // AW first, W three cycles later
      s_awaddr = 32'h8000_0074; s_awvalid = 1'b1;
      step();
      s_awvalid = 1'b0;
      check("awfirst_awready", 32'(s_awready), 32'd0);
      check("awfirst_wready",  32'(s_wready),  32'd1);
      repeat (2) begin
         step();
         check("awfirst_wait_awready", 32'(s_awready), 32'd0);
         check("awfirst_wait_bvalid",  32'(s_bvalid),  32'd0);
      end
      s_wdata = 32'h5A5A_0002; s_wstrb = 4'hF; s_wvalid = 1'b1;
      step();
      s_wvalid = 1'b0;
      check("awfirst_bvalid_early", 32'(s_bvalid), 32'd0);
      b_q.push_back(2'b00);
      step();
      check("awfirst_bvalid", 32'(s_bvalid), 32'd1);
      pop_b("awfirst_bresp");
      step();
      do_read(32'h8000_0074, 2'b00, 32'h5A5A_0002);

      // Write backpressure: second write buffers, then both B beats in order
      s_bready = 1'b0;
      s_awaddr = 32'h8000_0060; s_wdata = 32'h600D_0001; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      step();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      b_q.push_back(2'b00);
      step();
      check("bp_bvalid_first", 32'(s_bvalid),  32'd1);
      check("bp_awready_free", 32'(s_awready), 32'd1);
      check("bp_wready_free",  32'(s_wready),  32'd1);
      s_awaddr = 32'h8000_2000; s_wdata = 32'h0BAD_0BAD; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      step();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      b_q.push_back(2'b11);
      check("bp_awready_full", 32'(s_awready), 32'd0);
      check("bp_wready_full",  32'(s_wready),  32'd0);
      step();
      check("bp_awready_stall", 32'(s_awready), 32'd0);
      check("bp_bvalid_stall",  32'(s_bvalid),  32'd1);
      s_bready = 1'b1;
      pop_b("bp_bresp_1");
      step();
      check("bp_bvalid_second", 32'(s_bvalid), 32'd1);
      pop_b("bp_bresp_2");
      step();
      check("bp_bvalid_clear", 32'(s_bvalid), 32'd0);
      do_read(32'h8000_0060, 2'b00, 32'h600D_0001);
      do_read(32'h8000_0000, 2'b00, 32'h0BAD_C0DE);

      // Read backpressure: arready low, rdata stable while rready low
      s_rready = 1'b0;
      s_araddr = 32'h8000_0010; s_arvalid = 1'b1;
      step();
      s_araddr = 32'h8000_0020;
      check("rbp_rvalid",  32'(s_rvalid),  32'd1);
      check("rbp_arready", 32'(s_arready), 32'd0);
      check("rbp_rdata",   s_rdata,        32'hDEAD_BEEF);
      repeat (3) begin
         step();
         check("rbp_hold_arready", 32'(s_arready), 32'd0);
         check("rbp_hold_rdata",   s_rdata,        32'hDEAD_BEEF);
      end
      s_rready = 1'b1;
      step();
      check("rbp_rvalid_clear", 32'(s_rvalid),  32'd0);
      check("rbp_arready_back", 32'(s_arready), 32'd1);
      step();
      s_arvalid = 1'b0;
      check("rbp_second_rvalid", 32'(s_rvalid), 32'd1);
      check("rbp_second_rdata",  s_rdata,       32'h0102_0304);
      step();
      check("rbp_second_clear", 32'(s_rvalid), 32'd0);

      // Reset mid-operation: captured AW and pending R are discarded
      s_rready = 1'b0;
      s_awaddr = 32'h8000_0030; s_awvalid = 1'b1;
      s_araddr = 32'h8000_0030; s_arvalid = 1'b1;
      step();
      s_awvalid = 1'b0; s_arvalid = 1'b0;
      check("mid_rst_rvalid_before", 32'(s_rvalid), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_awready", 32'(s_awready), 32'd0);
      step();
      rst = 1'b0;
      #1;
      check("mid_rst_awready_after", 32'(s_awready), 32'd1);
      check("mid_rst_rvalid_after",  32'(s_rvalid),  32'd0);
      s_rready = 1'b1;
      s_wdata = 32'h9999_9999; s_wstrb = 4'hF; s_wvalid = 1'b1;
      step();
      s_wvalid = 1'b0;
      repeat (3) begin
         step();
         check("mid_rst_no_bvalid", 32'(s_bvalid), 32'd0);
      end
      s_awaddr = 32'h8000_0040; s_awvalid = 1'b1;
      step();
      s_awvalid = 1'b0;
      b_q.push_back(2'b00);
      step();
      check("mid_rst_late_bvalid", 32'(s_bvalid), 32'd1);
      pop_b("mid_rst_late_bresp");
      step();
      do_read(32'h8000_0030, 2'b00, 32'h3030_3030);
      do_read(32'h8000_0040, 2'b00, 32'h9999_9999);

      // Same-edge read and commit to one word return the old value
      s_awaddr = 32'h8000_0050; s_wdata = 32'h2222_2222; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      step();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      s_araddr = 32'h8000_0050; s_arvalid = 1'b1;
      step();
      s_arvalid = 1'b0;
      check("coll_bvalid", 32'(s_bvalid), 32'd1);
      check("coll_rvalid", 32'(s_rvalid), 32'd1);
      check("coll_rdata",  s_rdata,       32'h1111_1111);
      step();
      do_read(32'h8000_0050, 2'b00, 32'h2222_2222);

      check("sb_b_empty", 32'(b_q.size()), 32'd0);
      check("sb_r_empty", 32'(r_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
